store_ctrl: RTL
===============

# store_ctrl

Sequencer between the core's load/store stage and the single-port synchronous data RAM. Accepts one memory request at a time over a valid/ready handshake. Executes word stores as a single write, sub-word stores as a read-modify-write with byte-lane merge, and loads as a single read. Reports completion, and flags misaligned or illegal requests without touching memory.

## Interface
- `ADDR_W`, default 32: byte-address width; memory word address is `ADDR_W-2` bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; transfer on the clock edge where `req_valid && req_ready`.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_size` in 3: size code.
  - 000 = byte, 001 = half, 010 = word.
  - Other codes are illegal.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: valid with `rsp_valid`; 1 = request rejected.
- `rsp_rdata` out 32: raw RAM word for loads; holds its value until the next load completes.
- `mem_addr` out ADDR_W-2: word address, equal to latched `req_addr[ADDR_W-1:2]`.
- `mem_re` out 1: RAM read strobe; `mem_rdata` is valid the following cycle.
- `mem_we` out 1: RAM write strobe.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data.
- `mem_wstrb` out 4: per-byte write enable. Present only with `STORE_CTRL_WSTRB_EN`.

## Operation
- States: IDLE, READ, CAPT, WRITE, RESP.
- On accept, latch wr, size, addr, wdata. Next state is chosen as follows:
  - Error, meaning illegal size, half with addr[0]=1, or word with addr[1:0]≠0: go to RESP with err=1.
  - Word store: go to WRITE.
  - Byte/half store or any load: go to READ.
- READ: `mem_re`=1, then go to CAPT.
- CAPT: behaviour depends on request type.
  - Load: register `mem_rdata` into `rsp_rdata`, then go to RESP.
  - Store: register the merged word, then go to WRITE.
- Merge rule: result is the read word with only the target lanes replaced.
  - Byte: lane addr[1:0] takes wdata[7:0].
  - Half: lanes {2·addr[1]+1, 2·addr[1]} take wdata[15:0].
- WRITE: `mem_we`=1.
  - `mem_wdata` is the merged word for sub-word stores, wdata for word stores.
  - Next state is RESP.
- RESP: `rsp_valid`=1, then go to IDLE.
- Memory strobes and `rsp_valid` are decoded from state only (Moore). `mem_re` and `mem_we` are never high together.
- `mem_re`/`mem_we` are never asserted for an error request.
- `req_valid` outside IDLE is ignored; the requester holds its request until `req_ready`.
- Loads do no extraction or sign extension; the consumer does that.

## Timing
- Cycle 0 = accept edge. Latency from accept to `rsp_valid`:
  - Error: `rsp_valid` in cycle 1.
  - Word store: `mem_we` cycle 1, `rsp_valid` cycle 2.
  - Load: `mem_re` cycle 1, capture cycle 2, `rsp_valid` cycle 3.
  - Sub-word store: `mem_re` cycle 1, merge cycle 2, `mem_we` cycle 3, `rsp_valid` cycle 4.
- `req_ready` rises the cycle after RESP. Minimum request spacing is latency+1 cycles.
- Reset values: state IDLE, `req_ready`=1, and every other output 0 (`rsp_rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb` included).
- Reset asserted mid-operation forces IDLE immediately and deasserts strobes asynchronously. The request is dropped with no response.
- If reset hits before the WRITE edge, no memory write occurs.

## Configuration
- `STORE_CTRL_WSTRB_EN` defined:
  - `mem_wstrb` port exists.
  - Sub-word stores skip READ/CAPT and go straight to WRITE, with 2-cycle latency.
  - `mem_wdata` = wdata lane-replicated (byte ×4, half ×2).
  - `mem_wstrb` = 0001<<addr[1:0] for byte, 0011<<(2·addr[1]) for half, 1111 for word.
  - `mem_wstrb` is 0000 outside WRITE.
- Not defined: no `mem_wstrb` port; the RAM writes whole words and the read-modify-write path above is used.

## Test plan
- Word store addr 0x100, data 0xDEADBEEF -> `mem_we` cycle 1, `mem_addr`=0x40, `mem_wdata`=0xDEADBEEF, `rsp_valid` cycle 2, err=0.
- Byte store addr 0x102, data 0x000000AB, RAM word 0x11223344 -> `mem_re` cycle 1, `mem_wdata`=0x11AB3344 cycle 3, `rsp_valid` cycle 4.
- Half store addr 0x106, data 0x0000BEEF, RAM word 0x11223344 -> `mem_wdata`=0xBEEF3344. With `STORE_CTRL_WSTRB_EN`: `mem_wstrb`=1100, `mem_wdata`=0xBEEFBEEF, no `mem_re`.
- Half store addr 0x101 and word load addr 0x102 -> each gives `rsp_valid`+`rsp_err` cycle 1, zero `mem_re`/`mem_we` pulses.
- Load addr 0x200, RAM 0xCAFEF00D -> `rsp_rdata`=0xCAFEF00D with `rsp_valid` cycle 3. Back-to-back second request held on `req_valid` is accepted cycle 4.
- Sub-word store with `rst` pulsed during CAPT -> no `mem_we`, no `rsp_valid`, all outputs at reset values, `req_ready`=1.

Source files
------------

// File: rtl/store_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_ctrl_if
// Bundles the request/response handshake of the load/store stage and the
// single-port synchronous data RAM bus used by store_ctrl.
//
// Signals:
//   req_valid/req_ready   request handshake (transfer when both high)
//   req_wr, req_size      store/load and size code (000 byte, 001 half, 010 word)
//   req_addr, req_wdata   byte address and right-aligned store data
//   rsp_valid, rsp_err    one-cycle completion pulse and reject flag
//   rsp_rdata             raw RAM word of the last completed load
//   mem_addr              RAM word address
//   mem_re, mem_we        RAM read / write strobes
//   mem_wdata, mem_rdata  RAM write / read data
//   mem_wstrb             per-byte write enable (only with STORE_CTRL_WSTRB_EN)
//
// Modports:
//   slave  - the sequencer (store_ctrl)
//   master - the environment driving requests and modelling the RAM
// ---------------------------------------------------------------------------
interface store_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef STORE_CTRL_WSTRB_EN
  logic [3:0]        mem_wstrb;
`endif

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_size,
    input  req_addr,
    input  req_wdata,
    input  mem_rdata,
`ifdef STORE_CTRL_WSTRB_EN
    output mem_wstrb,
`endif
    output req_ready,
    output rsp_valid,
    output rsp_err,
    output rsp_rdata,
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata
  );

  modport master (
    output req_valid,
    output req_wr,
    output req_size,
    output req_addr,
    output req_wdata,
    output mem_rdata,
`ifdef STORE_CTRL_WSTRB_EN
    input  mem_wstrb,
`endif
    input  req_ready,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_rdata,
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata
  );

endinterface

// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
// Sequencer between the load/store stage and a single-port synchronous data
// RAM. One request at a time: word stores are a single write, sub-word stores
// a read-modify-write with byte-lane merge, loads a single read. Misaligned or
// illegal-size requests are answered with rsp_err without any RAM access.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (drops any request in flight)
//   bus  store_ctrl_if.slave: request/response handshake and RAM bus
//
// Build option:
//   STORE_CTRL_WSTRB_EN - RAM has byte write enables (mem_wstrb); sub-word
//   stores are written directly with lane-replicated data instead of the
//   read-modify-write sequence.
//
// Latency from the accept edge to rsp_valid: error 1, word store 2, load 3,
// sub-word store 4 (2 with STORE_CTRL_WSTRB_EN).
// ---------------------------------------------------------------------------
module store_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst,
  store_ctrl_if.slave bus
);

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              wr_r;
  logic [2:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;   // store data, later the merged word
  logic              err_r;
  logic [31:0]       rdata_r;
  logic              accept_s;
  logic              bad_s;
`ifdef STORE_CTRL_WSTRB_EN
  logic [3:0]        strb_r;
`endif

  // Illegal size code or an address not aligned to the access size.
  function automatic logic req_illegal(input logic [2:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace only the addressed byte lanes of the RAM word with store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] merged;
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged        = old_word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0]  = wdata[15:0];
        end
      end
      default: merged = wdata;
    endcase
    return merged;
  endfunction

`ifdef STORE_CTRL_WSTRB_EN
  // Copy the right-aligned store data into every lane it could target.
  function automatic logic [31:0] replicate_lanes(input logic [31:0] wdata,
                                                  input logic [2:0]  size);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

  // Byte write enables for the addressed lanes.
  function automatic logic [3:0] lane_strobes(input logic [2:0] size,
                                              input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << lane;
      SZ_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction
`endif

  assign accept_s = bus.req_valid && (state_r == S_IDLE);
  assign bad_s    = req_illegal(bus.req_size, bus.req_addr[1:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bad_s) begin
            state_s = S_RESP;
`ifdef STORE_CTRL_WSTRB_EN
          end else if (bus.req_wr) begin
`else
          end else if (bus.req_wr && (bus.req_size == SZ_WORD)) begin
`endif
            state_s = S_WRITE;
          end else begin
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: state_s = S_CAPT;
      S_CAPT: begin
        if (wr_r) begin
          state_s = S_WRITE;
        end else begin
          state_s = S_RESP;
        end
      end
      S_WRITE: state_s = S_RESP;
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Request latch on accept; load capture or lane merge in CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      size_r  <= 3'b000;
      addr_r  <= '0;
      data_r  <= 32'h0000_0000;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
`ifdef STORE_CTRL_WSTRB_EN
      strb_r  <= 4'b0000;
`endif
    end else if (accept_s) begin
      wr_r   <= bus.req_wr;
      size_r <= bus.req_size;
      addr_r <= bus.req_addr;
      err_r  <= bad_s;
`ifdef STORE_CTRL_WSTRB_EN
      data_r <= replicate_lanes(bus.req_wdata, bus.req_size);
      strb_r <= lane_strobes(bus.req_size, bus.req_addr[1:0]);
`else
      data_r <= bus.req_wdata;
`endif
    end else if (state_r == S_CAPT) begin
      // mem_rdata holds the word requested in READ during this cycle.
      if (wr_r) begin
        data_r <= merge_lanes(bus.mem_rdata, data_r, size_r, addr_r[1:0]);
      end else begin
        rdata_r <= bus.mem_rdata;
      end
    end
  end

  // Strobes and response are decoded from the state register only, so the
  // asynchronous reset drops them immediately.
  assign bus.req_ready = (state_r == S_IDLE);
  assign bus.rsp_valid = (state_r == S_RESP);
  assign bus.rsp_err   = (state_r == S_RESP) && err_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.mem_addr  = addr_r[ADDR_W-1:2];
  assign bus.mem_re    = (state_r == S_READ);
  assign bus.mem_we    = (state_r == S_WRITE);
  assign bus.mem_wdata = data_r;
`ifdef STORE_CTRL_WSTRB_EN
  assign bus.mem_wstrb = (state_r == S_WRITE) ? strb_r : 4'b0000;
`endif

endmodule
